// File: rtl/wb_scoreboard_pkg.sv
// vliw_pkg: shared constants and slot naming for the VLIW issue/writeback path.
//   NUM_SLOTS   issue/result slots per bundle
//   XLEN        register data width
//   REG_ADDR_W  register index width
//   NUM_REGS    architectural register count (x0 hardwired to zero)
//   slot_e      slot index: 0=LSU, 1=IXU1, 2=IXU2
package vliw_pkg;
  localparam int NUM_SLOTS  = 3;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    SLOT_LSU  = 2'd0,
    SLOT_IXU1 = 2'd1,
    SLOT_IXU2 = 2'd2
  } slot_e;
endpackage

// File: rtl/wb_scoreboard_regsb.sv
// reg_scoreboard: pending-write (busy) vector plus issue hazard detection.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   iss_valid, iss_wr              per-slot issue valid / writes-destination
//   iss_rd, iss_rs1, iss_rs2       per-slot register indices (packed by slot)
//   clr                            busy bits to clear this edge (writebacks)
//   busy                           registered pending-write vector
//   stall                          combinational: bundle cannot issue
//   dup                            combinational: two valid writers share an rd
module reg_scoreboard import vliw_pkg::*; #(
  parameter int NUM_SLOTS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SLOTS-1:0]            iss_valid,
  input  logic [NUM_SLOTS-1:0]            iss_wr,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] iss_rd,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] iss_rs1,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] iss_rs2,
  input  logic [NUM_REGS-1:0]             clr,
  output logic [NUM_REGS-1:0]             busy,
  output logic                            stall,
  output logic                            dup
);
  logic                  hazard;
  logic                  accept;
  logic [NUM_REGS-1:0]   set;
  logic [NUM_REGS-1:0]   busy_next;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;

  always_comb begin
    hazard = 1'b0;
    dup    = 1'b0;
    rd     = '0;
    rs1    = '0;
    rs2    = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      rd  = iss_rd [s*REG_ADDR_W +: REG_ADDR_W];
      rs1 = iss_rs1[s*REG_ADDR_W +: REG_ADDR_W];
      rs2 = iss_rs2[s*REG_ADDR_W +: REG_ADDR_W];
      if (iss_valid[s]) begin
        if (rs1 != '0 && busy[rs1])               hazard = 1'b1;  // RAW
        if (rs2 != '0 && busy[rs2])               hazard = 1'b1;  // RAW
        if (iss_wr[s] && rd != '0 && busy[rd])    hazard = 1'b1;  // WAW
        for (int t = s + 1; t < NUM_SLOTS; t++)
          if (iss_valid[t] && iss_wr[s] && iss_wr[t] && rd != '0 &&
              rd == iss_rd[t*REG_ADDR_W +: REG_ADDR_W])
            dup = 1'b1;
      end
    end
    stall = hazard | dup;
  end

  assign accept = (|iss_valid) & ~stall;

  always_comb begin
    set = '0;
    for (int s = 0; s < NUM_SLOTS; s++)
      if (accept && iss_valid[s] && iss_wr[s])
        set[iss_rd[s*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
    // Set wins over a same-edge clear; x0 is never pending.
    busy_next    = (busy & ~clr) | set;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end
endmodule

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: issue scoreboard plus result writeback arbitration.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   iss_valid/iss_wr/iss_rd/rs1/rs2 per-slot issue bundle
//   iss_stall                       combinational: bundle not accepted
//   res_valid/res_rd/res_data       per-slot execution results
//   rf_wr_en/rf_rd/rf_wr_data       registered register-file write ports
//   busy                            pending-write vector
//   wb_count, drop_count            saturating writeback / drop counters
//   err_dup                         sticky duplicate-destination error
module wb_scoreboard import vliw_pkg::*; #(
  parameter int NUM_SLOTS = 3,
  parameter int XLEN      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SLOTS-1:0]            iss_valid,
  input  logic [NUM_SLOTS-1:0]            iss_wr,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] iss_rd,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] iss_rs1,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] iss_rs2,
  output logic                            iss_stall,
  input  logic [NUM_SLOTS-1:0]            res_valid,
  input  logic [NUM_SLOTS*REG_ADDR_W-1:0] res_rd,
  input  logic [NUM_SLOTS*XLEN-1:0]       res_data,
  output logic [NUM_SLOTS-1:0]            rf_wr_en,
  output logic [NUM_SLOTS*REG_ADDR_W-1:0] rf_rd,
  output logic [NUM_SLOTS*XLEN-1:0]       rf_wr_data,
  output logic [NUM_REGS-1:0]             busy,
  output logic [31:0]                     wb_count,
  output logic [15:0]                     drop_count,
  output logic                            err_dup
);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0]  keep;
  logic [NUM_REGS-1:0]   clr;
  logic [CNT_W-1:0]      n_wb, n_drop;
  logic [REG_ADDR_W-1:0] rd;
  logic                  shadowed;
  logic                  dup;
  logic [32:0]           wb_sum;
  logic [16:0]           drop_sum;

  reg_scoreboard #(.NUM_SLOTS(NUM_SLOTS)) u_regsb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_wr    (iss_wr),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .clr       (clr),
    .busy      (busy),
    .stall     (iss_stall),
    .dup       (dup)
  );

  // A result survives only if it targets a pending nonzero rd and no
  // higher-index slot writes the same rd this cycle (younger slot wins).
  always_comb begin
    keep     = '0;
    clr      = '0;
    n_wb     = '0;
    n_drop   = '0;
    rd       = '0;
    shadowed = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      rd       = res_rd[s*REG_ADDR_W +: REG_ADDR_W];
      shadowed = 1'b0;
      for (int t = s + 1; t < NUM_SLOTS; t++)
        if (res_valid[t] && res_rd[t*REG_ADDR_W +: REG_ADDR_W] == rd)
          shadowed = 1'b1;
      if (res_valid[s]) begin
        if (rd != '0 && busy[rd] && !shadowed) begin
          keep[s] = 1'b1;
          clr[rd] = 1'b1;
          n_wb    = n_wb + 1'b1;
        end else begin
          n_drop  = n_drop + 1'b1;
        end
      end
    end
  end

  assign wb_sum   = {1'b0, wb_count}   + 33'(n_wb);
  assign drop_sum = {1'b0, drop_count} + 17'(n_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en   <= '0;
      rf_rd      <= '0;
      rf_wr_data <= '0;
      wb_count   <= '0;
      drop_count <= '0;
      err_dup    <= 1'b0;
    end else begin
      rf_wr_en <= keep;
      for (int s = 0; s < NUM_SLOTS; s++)
        if (keep[s]) begin
          rf_rd     [s*REG_ADDR_W +: REG_ADDR_W] <= res_rd  [s*REG_ADDR_W +: REG_ADDR_W];
          rf_wr_data[s*XLEN       +: XLEN]       <= res_data[s*XLEN       +: XLEN];
        end
      wb_count   <= wb_sum[32]   ? '1 : wb_sum[31:0];
      drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
      if (dup) err_dup <= 1'b1;
    end
  end
endmodule
